// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU/funct encodings, mult/div FSM
// states and the EX/MEM register layout.
package ex_pkg;

    localparam int SIZE = 32;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;
    localparam logic [2:0] ALU_ADD2  = 3'b111;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    typedef struct packed {
        logic [SIZE-1:0] alu_result;
        logic            zero;
        logic [SIZE-1:0] write_data;
        logic [4:0]      write_reg;
        logic [SIZE-1:0] branch_target;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
    } exmem_t;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic uses_hilo(input logic [5:0] f);
        return is_md_funct(f) || (f == F_MFHI) || (f == F_MFLO);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, plus mult/div status.
// Handshake: no valid/ready; hit advances everything, md_stall asks upstream to hold and re-present.
interface ex_mem_stage_if;
    import ex_pkg::*;

    logic [SIZE-1:0] readData1;
    logic [SIZE-1:0] readData2;
    logic [SIZE-1:0] signExImmediate;
    logic [SIZE-1:0] nextPc;
    logic            RegDst;
    logic            ALUSrc;
    logic            MemtoReg;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            Branch;
    logic [2:0]      ALUOp;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [5:0]      funct;

    logic [SIZE-1:0] aluResult_OUT;
    logic            zero_OUT;
    logic [SIZE-1:0] writeData_OUT;
    logic [4:0]      writeReg_OUT;
    logic [SIZE-1:0] branchTarget_OUT;
    logic            MemtoReg_OUT;
    logic            RegWrite_OUT;
    logic            MemRead_OUT;
    logic            MemWrite_OUT;
    logic            Branch_OUT;
    logic            md_busy;
    logic            md_stall;
    logic [0:0]      md_state;
    logic [4:0]      md_count;

    modport master (
        output readData1, readData2, signExImmediate, nextPc,
        output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
        output ALUOp, rt, rd, funct,
        input  aluResult_OUT, zero_OUT, writeData_OUT, writeReg_OUT, branchTarget_OUT,
        input  MemtoReg_OUT, RegWrite_OUT, MemRead_OUT, MemWrite_OUT, Branch_OUT,
        input  md_busy, md_stall, md_state, md_count
    );

    modport slave (
        input  readData1, readData2, signExImmediate, nextPc,
        input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
        input  ALUOp, rt, rd, funct,
        output aluResult_OUT, zero_OUT, writeData_OUT, writeReg_OUT, branchTarget_OUT,
        output MemtoReg_OUT, RegWrite_OUT, MemRead_OUT, MemWrite_OUT, Branch_OUT,
        output md_busy, md_stall, md_state, md_count
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI and LO.
// Signed ops run on magnitudes and are sign-corrected when HI/LO are written.
module mul_div_unit
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hit,
    input  logic            start,
    input  logic            op_div,
    input  logic            op_signed,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            busy,
    output logic [SIZE-1:0] hi,
    output logic [SIZE-1:0] lo,
    output logic [0:0]      state,
    output logic [4:0]      count
);

    logic [0:0]      state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [SIZE-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [SIZE-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [SIZE-1:0] opnd_q, opnd_d, dividend_q, dividend_d;
    logic            is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d;

    logic [SIZE:0]     sum, shifted, diff;
    logic [SIZE-1:0]   step_hi, step_lo, mag_a, mag_b;
    logic [2*SIZE-1:0] prod;
    logic              sa, sb;

    always_comb begin
        sa    = op_signed & a[SIZE-1];
        sb    = op_signed & b[SIZE-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;

        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {acc_hi_q, acc_lo_q[SIZE-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (is_div_q) begin
            // Restoring step: keep the difference only when it did not go negative.
            if (!diff[SIZE]) begin
                step_hi = diff[SIZE-1:0];
                step_lo = {acc_lo_q[SIZE-2:0], 1'b1};
            end else begin
                step_hi = shifted[SIZE-1:0];
                step_lo = {acc_lo_q[SIZE-2:0], 1'b0};
            end
        end else begin
            step_hi = sum[SIZE:1];
            step_lo = {sum[0], acc_lo_q[SIZE-1:1]};
        end
        prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        dividend_d = dividend_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        if (hit) begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        state_d    = MD_BUSY;
                        count_d    = '0;
                        acc_hi_d   = '0;
                        acc_lo_d   = op_div ? mag_a : mag_b;
                        opnd_d     = op_div ? mag_b : mag_a;
                        dividend_d = a;
                        is_div_d   = op_div;
                        neg_d      = sa ^ sb;
                        rem_neg_d  = sa;
                        dz_d       = op_div & (b == '0);
                    end
                end
                default: begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    count_d  = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d = MD_IDLE;
                        count_d = '0;
                        if (!is_div_q) begin
                            hi_d = prod[2*SIZE-1:SIZE];
                            lo_d = prod[SIZE-1:0];
                        end else if (dz_q) begin
                            hi_d = dividend_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_neg_q ? -step_hi : step_hi;
                            lo_d = neg_q ? -step_lo : step_lo;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            dividend_q <= dividend_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
        end
    end

    assign busy  = (state_q == MD_BUSY);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign state = state_q;
    assign count = count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: ALU decode and datapath, branch target, destination select,
// mult/div interlock and the falling-edge EX/MEM register.
module ex_mem_stage
    import ex_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hit,
    ex_mem_stage_if.slave  bus
);

    exmem_t exmem_q, exmem_d;

    logic [SIZE-1:0] b_op, alu_res, sra_res, hi, lo;
    logic [4:0]      shamt;
    logic            is_rtype, md_op, md_start, md_busy, md_stall, bubble;
    logic [0:0]      md_state;
    logic [4:0]      md_count;

    assign b_op     = bus.ALUSrc ? bus.signExImmediate : bus.readData2;
    assign shamt    = bus.signExImmediate[10:6];
    assign sra_res  = $signed(bus.readData2) >>> shamt;
    assign is_rtype = (bus.ALUOp == ALU_RTYPE);
    assign md_op    = is_rtype & is_md_funct(bus.funct);
    // Anything touching HI/LO waits until the unit is idle, including the completion edge.
    assign md_stall = md_busy & is_rtype & uses_hilo(bus.funct);
    assign md_start = hit & md_op & ~md_stall;
    assign bubble   = md_op | md_stall;

    always_comb begin
        alu_res = '0;
        case (bus.ALUOp)
            ALU_ADD, ALU_ADD2: alu_res = bus.readData1 + b_op;
            ALU_SUB:           alu_res = bus.readData1 - b_op;
            ALU_AND:           alu_res = bus.readData1 & b_op;
            ALU_OR:            alu_res = bus.readData1 | b_op;
            ALU_XOR:           alu_res = bus.readData1 ^ b_op;
            ALU_SLT:           alu_res = {31'b0, $signed(bus.readData1) < $signed(b_op)};
            default: begin
                case (bus.funct)
                    F_ADD, F_ADDU: alu_res = bus.readData1 + b_op;
                    F_SUB, F_SUBU: alu_res = bus.readData1 - b_op;
                    F_AND:         alu_res = bus.readData1 & b_op;
                    F_OR:          alu_res = bus.readData1 | b_op;
                    F_XOR:         alu_res = bus.readData1 ^ b_op;
                    F_NOR:         alu_res = ~(bus.readData1 | b_op);
                    F_SLT:         alu_res = {31'b0, $signed(bus.readData1) < $signed(b_op)};
                    F_SLTU:        alu_res = {31'b0, bus.readData1 < b_op};
                    F_SLL:         alu_res = bus.readData2 << shamt;
                    F_SRL:         alu_res = bus.readData2 >> shamt;
                    F_SRA:         alu_res = sra_res;
                    F_MFHI:        alu_res = hi;
                    F_MFLO:        alu_res = lo;
                    default:       alu_res = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        exmem_d = '0;
        if (!bubble) begin
            exmem_d.alu_result    = alu_res;
            exmem_d.zero          = (alu_res == '0);
            exmem_d.write_data    = bus.readData2;
            exmem_d.write_reg     = bus.RegDst ? bus.rd : bus.rt;
            exmem_d.branch_target = bus.nextPc + {bus.signExImmediate[SIZE-3:0], 2'b00};
            exmem_d.mem_to_reg    = bus.MemtoReg;
            exmem_d.reg_write     = bus.RegWrite;
            exmem_d.mem_read      = bus.MemRead;
            exmem_d.mem_write     = bus.MemWrite;
            exmem_d.branch        = bus.Branch;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= '0;
        end else if (hit) begin
            exmem_q <= exmem_d;
        end
    end

    mul_div_unit u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (hit),
        .start     (md_start),
        .op_div    (bus.funct[1]),
        .op_signed (~bus.funct[0]),
        .a         (bus.readData1),
        .b         (bus.readData2),
        .busy      (md_busy),
        .hi        (hi),
        .lo        (lo),
        .state     (md_state),
        .count     (md_count)
    );

    assign bus.aluResult_OUT    = exmem_q.alu_result;
    assign bus.zero_OUT         = exmem_q.zero;
    assign bus.writeData_OUT    = exmem_q.write_data;
    assign bus.writeReg_OUT     = exmem_q.write_reg;
    assign bus.branchTarget_OUT = exmem_q.branch_target;
    assign bus.MemtoReg_OUT     = exmem_q.mem_to_reg;
    assign bus.RegWrite_OUT     = exmem_q.reg_write;
    assign bus.MemRead_OUT      = exmem_q.mem_read;
    assign bus.MemWrite_OUT     = exmem_q.mem_write;
    assign bus.Branch_OUT       = exmem_q.branch;
    assign bus.md_busy          = md_busy;
    assign bus.md_stall         = md_stall;
    assign bus.md_state         = md_state;
    assign bus.md_count         = md_count;

endmodule
